// File: rtl/flag_cond_unit_if.sv
// rtl/flag_cond_unit_if.sv - flag/branch-condition bus between the EX stage and flag_cond_unit
//
// Purpose: bundles the ALU flag write, the B.cond and CBZ/CBNZ requests,
//          and the registered branch decision returned to fetch/PC logic.
// Signals:
//   flag_we, negative_in, zero_in, overflow_in, carry_out_in : flag write from the ALU
//   flush                                                    : kill this cycle's write and request
//   cond_valid, cond[3:0]                                    : B.cond request
//   cbz_valid, cbz_nz, reg_zero                              : CBZ/CBNZ request
//   flags_q[3:0]                                             : registered {N,Z,V,C}
//   branch_valid, branch_taken, req_conflict                 : registered decision
// Modports: master = requester (EX stage / bench), slave = flag_cond_unit.
interface flag_cond_unit_if;
   logic       flag_we;
   logic       negative_in;
   logic       zero_in;
   logic       overflow_in;
   logic       carry_out_in;
   logic       flush;
   logic       cond_valid;
   logic [3:0] cond;
   logic       cbz_valid;
   logic       cbz_nz;
   logic       reg_zero;
   logic [3:0] flags_q;
   logic       branch_valid;
   logic       branch_taken;
   logic       req_conflict;

   modport master (
      output flag_we, negative_in, zero_in, overflow_in, carry_out_in,
      output flush, cond_valid, cond, cbz_valid, cbz_nz, reg_zero,
      input  flags_q, branch_valid, branch_taken, req_conflict
   );

   modport slave (
      input  flag_we, negative_in, zero_in, overflow_in, carry_out_in,
      input  flush, cond_valid, cond, cbz_valid, cbz_nz, reg_zero,
      output flags_q, branch_valid, branch_taken, req_conflict
   );
endinterface

// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - NZVC flag register and B.cond / CBZ / CBNZ branch decision unit
//
// Purpose: latches ALU flags on flag-setting instructions, evaluates ARMv8
//          condition codes or a register-zero test, and presents a registered
//          branch decision one cycle after the request.
// Parameters:
//   FORWARD : 1 = same-cycle flag write is bypassed into evaluation,
//             0 = evaluation sees only the registered flags.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : flag_cond_unit_if.slave (flag write, requests, decision outputs)
module flag_cond_unit #(
   parameter bit FORWARD = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   flag_cond_unit_if.slave   bus
);

   logic [3:0] r_flags;
   logic       r_branch_valid;
   logic       r_branch_taken;
   logic       r_req_conflict;

   logic [3:0] w_in_flags;
   logic [3:0] w_ef;
   logic       w_n, w_z, w_v, w_c;
   logic       w_cond_res;
   logic       w_req;
   logic       w_taken;

   assign w_in_flags = {bus.negative_in, bus.zero_in, bus.overflow_in, bus.carry_out_in};

   // Bypass lets a branch in the same cycle as ADDS/SUBS see the new flags.
   assign w_ef = (FORWARD && bus.flag_we) ? w_in_flags : r_flags;
   assign {w_n, w_z, w_v, w_c} = w_ef;

   always_comb begin
      w_cond_res = 1'b0;
      case (bus.cond)
         4'b0000: w_cond_res = w_z;
         4'b0001: w_cond_res = !w_z;
         4'b0010: w_cond_res = w_c;
         4'b0011: w_cond_res = !w_c;
         4'b0100: w_cond_res = w_n;
         4'b0101: w_cond_res = !w_n;
         4'b0110: w_cond_res = w_v;
         4'b0111: w_cond_res = !w_v;
         4'b1000: w_cond_res = w_c & !w_z;
         4'b1001: w_cond_res = !w_c | w_z;
         4'b1010: w_cond_res = (w_n == w_v);
         4'b1011: w_cond_res = (w_n != w_v);
         4'b1100: w_cond_res = !w_z & (w_n == w_v);
         4'b1101: w_cond_res = w_z | (w_n != w_v);
         // NV behaves as AL in ARMv8
         default: w_cond_res = 1'b1;
      endcase
   end

   assign w_req = (bus.cond_valid | bus.cbz_valid) & !bus.flush;

   // B.cond wins when both requests arrive together; the CBZ test is dropped.
   assign w_taken = bus.cond_valid ? w_cond_res : (bus.reg_zero ^ bus.cbz_nz);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flags        <= 4'b0000;
         r_branch_valid <= 1'b0;
         r_branch_taken <= 1'b0;
         r_req_conflict <= 1'b0;
      end else begin
         if (bus.flag_we && !bus.flush) begin
            r_flags <= w_in_flags;
         end
         r_branch_valid <= w_req;
         r_branch_taken <= w_req & w_taken;
         r_req_conflict <= bus.cond_valid & bus.cbz_valid & !bus.flush;
      end
   end

   assign bus.flags_q      = r_flags;
   assign bus.branch_valid = r_branch_valid;
   assign bus.branch_taken = r_branch_taken;
   assign bus.req_conflict = r_req_conflict;

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
Consumer end of the ALU flag interface. It latches the NZVC flags produced by the 64-bit adder/ALU on flag-setting instructions (ADDS/SUBS). It evaluates ARMv8 B.cond conditions and CBZ/CBNZ tests against those flags or a register-zero indication, and returns a registered branch decision to the fetch/PC logic one cycle later. It sits in the EX stage of the pipelined CPU, beside the ALU.

Parameters:
FORWARD, 1, 1 = a same-cycle flag write is bypassed into condition evaluation; 0 = evaluation uses only the registered flags.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
flag_we  input  1  load the four flag inputs this cycle
negative_in  input  1  N flag from the ALU
zero_in  input  1  Z flag from the ALU
overflow_in  input  1  V flag from the ALU
carry_out_in  input  1  C flag from the ALU
flush  input  1  pipeline flush; kills this cycle's write and request
cond_valid  input  1  B.cond request this cycle
cond  input  4  ARMv8 condition code
cbz_valid  input  1  CBZ/CBNZ request this cycle
cbz_nz  input  1  0 = CBZ, 1 = CBNZ
reg_zero  input  1  tested register is all zeros (from the zero-check of the register value)
flags_q  output  4  registered {N,Z,V,C}
branch_valid  output  1  registered: a decision is presented this cycle
branch_taken  output  1  registered decision; meaningful only when branch_valid=1
req_conflict  output  1  registered one-cycle pulse: cond_valid and cbz_valid were both asserted

Behaviour:
- Reset (async, any time including mid-request): flags_q=4'b0000, branch_valid=0, branch_taken=0, req_conflict=0. Any request in flight is lost; no decision appears after reset deasserts.
- Flag register:
  - On a rising edge with flag_we=1 and flush=0, flags_q <= {negative_in, zero_in, overflow_in, carry_out_in}.
  - Otherwise flags_q holds.
- Effective flags (EF):
  - If FORWARD=1 and flag_we=1, EF = the incoming flags.
  - Otherwise EF = flags_q.
- Condition table on EF (N,Z,V,C):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 NV: 1 (ARMv8 treats NV as always)
- CBZ/CBNZ: taken = reg_zero ^ cbz_nz. Flags are not used.
- Decision pipeline, latency 1 cycle:
  - At the edge, branch_valid <= (cond_valid|cbz_valid) & !flush.
  - branch_taken <= the evaluated result when valid, else 0.
- Simultaneous requests:
  - cond_valid has priority; the CBZ request is dropped.
  - req_conflict <= 1 for one cycle.
  - Under flush, req_conflict <= 0.
- No request: branch_valid <= 0 and branch_taken <= 0 on the next edge. Outputs are pulses, never sticky.
- Back-to-back requests on consecutive cycles each produce their own decision on consecutive cycles. There is no backpressure.
- A flag write and a request in the same cycle: the request sees the new flags when FORWARD=1 and the old flags when FORWARD=0. The write lands in either case.
- flush: suppresses the flag write and the request in the same cycle. It does not clear flags_q or an already-registered decision.

Test Plan:
- Reset mid-request: assert cond_valid=1, cond=1110, then raise reset before the edge -> immediately flags_q=0000, branch_valid=0. After reset release with no request, branch_valid stays 0.
- Flag load then EQ/NE: flag_we=1 with N,Z,V,C=0,1,0,1. Next cycle cond=0000 -> next cycle branch_valid=1, taken=1. Then cond=0001 -> taken=0.
- Forwarding, same cycle: flags_q=0000; flag_we=1 with flags 1,0,0,0 and cond=1011 (LT) in the same cycle.
  - FORWARD=1 -> taken=1.
  - FORWARD=0 -> taken=0.
  - flags_q=1000 afterwards in both builds.
- Signed compares: with N=1,V=1,Z=0, GE=1, LT=0, GT=1, LE=0. With Z=1, GT=0, LE=1. With C=1,Z=0, HI=1, LS=0.
- CBZ/CBNZ and conflict:
  - cbz_valid=1, cbz_nz=0, reg_zero=1 -> taken=1.
  - cbz_nz=1 -> taken=0.
  - cond_valid=1 (cond=0000, Z=0) and cbz_valid=1 (reg_zero=1) together -> branch_valid=1, taken=0, req_conflict=1 for exactly one cycle.
- Flush: flag_we=1 with flags 0,1,0,0, cond_valid=1 and flush=1 -> flags_q unchanged, branch_valid=0 next cycle. Back-to-back requests without flush -> branch_valid=1 on each following cycle.
